mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 42 ++++
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester handshakes (CPU, VGA) and memory-unit bus for mem_arbiter.
interface mem_arbiter_if;
  logic        CPU_REQ;
  logic        CPU_WE;
  logic [31:0] CPU_ADDR;
  logic [31:0] CPU_WDATA;
  logic        CPU_ACK;
  logic [31:0] CPU_RDATA;

  logic        VGA_REQ;
  logic        VGA_WE;
  logic [31:0] VGA_ADDR;
  logic [31:0] VGA_WDATA;
  logic        VGA_ACK;
  logic [31:0] VGA_RDATA;

  logic [31:0] MEM_ADDR;
  logic        MEM_N_WE;
  logic        MEM_N_OE;
  logic [31:0] MEM_IN;
  logic [31:0] MEM_OUT;

  logic        BUSY;

  // Arbiter side
  modport master (
    input  CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA,
    input  VGA_REQ, VGA_WE, VGA_ADDR, VGA_WDATA,
    input  MEM_OUT,
    output CPU_ACK, CPU_RDATA, VGA_ACK, VGA_RDATA,
    output MEM_ADDR, MEM_N_WE, MEM_N_OE, MEM_IN, BUSY
  );

  // Requester / memory side
  modport slave (
    output CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA,
    output VGA_REQ, VGA_WE, VGA_ADDR, VGA_WDATA,
    output MEM_OUT,
    input  CPU_ACK, CPU_RDATA, VGA_ACK, VGA_RDATA,
    input  MEM_ADDR, MEM_N_WE, MEM_N_OE, MEM_IN, BUSY
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin CPU/VGA arbiter driving a strobed memory unit
// (IDLE -> ACCESS for WAIT_CYCLES strobe-low cycles -> RECOVER with ACK).
module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic           CLK,
  input logic           RST,
  mem_arbiter_if.master bus
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DW    = 32;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] RECOVER = 2'd2;

  logic [1:0]       state,     state_nxt;
  logic [CNT_W-1:0] cnt,       cnt_nxt;
  logic             last_vga,  last_vga_nxt;
  logic             win_vga,   win_vga_nxt;
  logic             is_wr,     is_wr_nxt;
  logic [DW-1:0]    mem_addr,  mem_addr_nxt;
  logic [DW-1:0]    mem_in,    mem_in_nxt;
  logic [DW-1:0]    cpu_rdata, cpu_rdata_nxt;
  logic [DW-1:0]    vga_rdata, vga_rdata_nxt;
  logic             n_we,      n_we_nxt;
  logic             n_oe,      n_oe_nxt;
  logic             cpu_ack,   cpu_ack_nxt;
  logic             vga_ack,   vga_ack_nxt;
  logic             busy,      busy_nxt;
  logic             grant_vga_c;

  // Next-state, grant and registered-output computation
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    last_vga_nxt  = last_vga;
    win_vga_nxt   = win_vga;
    is_wr_nxt     = is_wr;
    mem_addr_nxt  = mem_addr;
    mem_in_nxt    = mem_in;
    cpu_rdata_nxt = cpu_rdata;
    vga_rdata_nxt = vga_rdata;
    n_we_nxt      = 1'b1;
    n_oe_nxt      = 1'b1;
    cpu_ack_nxt   = 1'b0;
    vga_ack_nxt   = 1'b0;

    // Contended: the side not granted last wins; otherwise the lone requester.
    grant_vga_c = (bus.CPU_REQ && bus.VGA_REQ) ? ~last_vga : bus.VGA_REQ;

    case (state)
      IDLE: begin
        if (bus.CPU_REQ || bus.VGA_REQ) begin
          state_nxt    = ACCESS;
          win_vga_nxt  = grant_vga_c;
          last_vga_nxt = grant_vga_c;
          is_wr_nxt    = grant_vga_c ? bus.VGA_WE    : bus.CPU_WE;
          mem_addr_nxt = grant_vga_c ? bus.VGA_ADDR  : bus.CPU_ADDR;
          mem_in_nxt   = grant_vga_c ? bus.VGA_WDATA : bus.CPU_WDATA;
          cnt_nxt      = CNT_W'(WAIT_CYCLES - 1);
          n_we_nxt     = ~is_wr_nxt;
          n_oe_nxt     = is_wr_nxt;
        end
      end
      ACCESS: begin
        if (cnt != '0) begin
          cnt_nxt  = cnt - CNT_W'(1);
          n_we_nxt = ~is_wr;
          n_oe_nxt = is_wr;
        end else begin
          state_nxt = RECOVER;
          if (win_vga) begin
            vga_ack_nxt = 1'b1;
            if (!is_wr) vga_rdata_nxt = bus.MEM_OUT;
          end else begin
            cpu_ack_nxt = 1'b1;
            if (!is_wr) cpu_rdata_nxt = bus.MEM_OUT;
          end
        end
      end
      RECOVER: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      last_vga  <= 1'b1;
      win_vga   <= 1'b0;
      is_wr     <= 1'b0;
      mem_addr  <= '0;
      mem_in    <= '0;
      cpu_rdata <= '0;
      vga_rdata <= '0;
      n_we      <= 1'b1;
      n_oe      <= 1'b1;
      cpu_ack   <= 1'b0;
      vga_ack   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      last_vga  <= last_vga_nxt;
      win_vga   <= win_vga_nxt;
      is_wr     <= is_wr_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_in    <= mem_in_nxt;
      cpu_rdata <= cpu_rdata_nxt;
      vga_rdata <= vga_rdata_nxt;
      n_we      <= n_we_nxt;
      n_oe      <= n_oe_nxt;
      cpu_ack   <= cpu_ack_nxt;
      vga_ack   <= vga_ack_nxt;
      busy      <= busy_nxt;
    end
  end

  assign bus.CPU_ACK   = cpu_ack;
  assign bus.CPU_RDATA = cpu_rdata;
  assign bus.VGA_ACK   = vga_ack;
  assign bus.VGA_RDATA = vga_rdata;
  assign bus.MEM_ADDR  = mem_addr;
  assign bus.MEM_N_WE  = n_we;
  assign bus.MEM_N_OE  = n_oe;
  assign bus.MEM_IN    = mem_in;
  assign bus.BUSY      = busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus hand-written multi-cycle sequences.
module tb_mem_arbiter;

  logic CLK = 1'b0;
  logic RST;
  logic RST1;

  always #5 CLK = ~CLK;

  mem_arbiter_if bus0 ();
  mem_arbiter_if bus1 ();

  mem_arbiter #(.WAIT_CYCLES(2)) u_dut0 (.CLK(CLK), .RST(RST),  .bus(bus0));
  mem_arbiter #(.WAIT_CYCLES(1)) u_dut1 (.CLK(CLK), .RST(RST1), .bus(bus1));

  // Memory contents: 0x10 holds 0x12345678, every other word {addr[15:0], ~addr[15:0]}
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h10) return 32'h1234_5678;
    return {a[15:0], ~a[15:0]};
  endfunction

  assign bus0.MEM_OUT = mem_model(bus0.MEM_ADDR);
  assign bus1.MEM_OUT = mem_model(bus1.MEM_ADDR);

  typedef struct {
    logic        rst;
    logic        creq;
    logic        cwe;
    logic [31:0] caddr;
    logic [31:0] cwd;
    logic        vreq;
    logic        vwe;
    logic [31:0] vaddr;
    logic [31:0] vwd;
    logic        n_oe;
    logic        n_we;
    logic        cack;
    logic        vack;
    logic        busy;
    logic [31:0] maddr;
    logic [31:0] min;
    logic [31:0] crd;
    logic [31:0] vrd;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic vec_t mk(
    input logic rst, input logic creq, input logic cwe, input logic [31:0] caddr, input logic [31:0] cwd,
    input logic vreq, input logic vwe, input logic [31:0] vaddr, input logic [31:0] vwd,
    input logic n_oe, input logic n_we, input logic cack, input logic vack, input logic busy,
    input logic [31:0] maddr, input logic [31:0] min, input logic [31:0] crd, input logic [31:0] vrd);
    vec_t v;
    v.rst = rst; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.vreq = vreq; v.vwe = vwe; v.vaddr = vaddr; v.vwd = vwd;
    v.n_oe = n_oe; v.n_we = n_we; v.cack = cack; v.vack = vack; v.busy = busy;
    v.maddr = maddr; v.min = min; v.crd = crd; v.vrd = vrd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic drive0(input logic creq, input logic cwe, input logic [31:0] caddr, input logic [31:0] cwd,
                        input logic vreq, input logic vwe, input logic [31:0] vaddr, input logic [31:0] vwd);
    bus0.CPU_REQ = creq; bus0.CPU_WE = cwe; bus0.CPU_ADDR = caddr; bus0.CPU_WDATA = cwd;
    bus0.VGA_REQ = vreq; bus0.VGA_WE = vwe; bus0.VGA_ADDR = vaddr; bus0.VGA_WDATA = vwd;
  endtask

  task automatic check_row(input int i);
    string t;
    t = $sformatf("row%0d", i);
    check_bit({t, ".n_oe"},     bus0.MEM_N_OE,  vecs[i].n_oe);
    check_bit({t, ".n_we"},     bus0.MEM_N_WE,  vecs[i].n_we);
    check_bit({t, ".cpu_ack"},  bus0.CPU_ACK,   vecs[i].cack);
    check_bit({t, ".vga_ack"},  bus0.VGA_ACK,   vecs[i].vack);
    check_bit({t, ".busy"},     bus0.BUSY,      vecs[i].busy);
    check({t, ".mem_addr"},     bus0.MEM_ADDR,  vecs[i].maddr);
    check({t, ".mem_in"},       bus0.MEM_IN,    vecs[i].min);
    check({t, ".cpu_rdata"},    bus0.CPU_RDATA, vecs[i].crd);
    check({t, ".vga_rdata"},    bus0.VGA_RDATA, vecs[i].vrd);
  endtask

  task automatic reset0();
    RST = 1'b1;
    drive0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  localparam logic [31:0] RD = 32'h1234_5678;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;
  localparam logic [31:0] P  = 32'h0040_FFBF;
  localparam logic [31:0] Q  = 32'h0080_FF7F;

  int          ack_cyc [6];
  logic        ack_vga [6];
  int          nacks;
  int          overlap;

  initial begin
    RST  = 1'b1;
    RST1 = 1'b1;
    drive0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    bus1.CPU_REQ = 1'b0; bus1.CPU_WE = 1'b0; bus1.CPU_ADDR = '0; bus1.CPU_WDATA = '0;
    bus1.VGA_REQ = 1'b0; bus1.VGA_WE = 1'b0; bus1.VGA_ADDR = '0; bus1.VGA_WDATA = '0;

    //             rst creq cwe caddr   cwd             vreq vwe vaddr  vwd   n_oe n_we cack vack busy maddr  min  crd  vrd
    vecs[0]  = mk(0, 1, 0, 32'h10, 32'h0,          0, 0, 32'h0,  32'h0, 1, 1, 0, 0, 0, 32'h0,  32'h0, 32'h0, 32'h0);
    vecs[1]  = mk(0, 1, 0, 32'h10, 32'h0,          0, 0, 32'h0,  32'h0, 0, 1, 0, 0, 1, 32'h10, 32'h0, 32'h0, 32'h0);
    vecs[2]  = mk(0, 1, 0, 32'h10, 32'h0,          0, 0, 32'h0,  32'h0, 0, 1, 0, 0, 1, 32'h10, 32'h0, 32'h0, 32'h0);
    vecs[3]  = mk(0, 1, 0, 32'h10, 32'h0,          0, 0, 32'h0,  32'h0, 1, 1, 1, 0, 1, 32'h10, 32'h0, RD,    32'h0);
    vecs[4]  = mk(0, 0, 0, 32'h0,  32'h0,          0, 0, 32'h0,  32'h0, 1, 1, 0, 0, 0, 32'h10, 32'h0, RD,    32'h0);
    vecs[5]  = mk(0, 1, 1, 32'h20, DB,             0, 0, 32'h0,  32'h0, 1, 1, 0, 0, 0, 32'h10, 32'h0, RD,    32'h0);
    vecs[6]  = mk(0, 1, 1, 32'h20, DB,             0, 0, 32'h0,  32'h0, 1, 0, 0, 0, 1, 32'h20, DB,    RD,    32'h0);
    vecs[7]  = mk(0, 1, 0, 32'h99, 32'h1111_1111,  0, 0, 32'h0,  32'h0, 1, 0, 0, 0, 1, 32'h20, DB,    RD,    32'h0);
    vecs[8]  = mk(0, 1, 1, 32'h20, DB,             0, 0, 32'h0,  32'h0, 1, 1, 1, 0, 1, 32'h20, DB,    RD,    32'h0);
    vecs[9]  = mk(0, 0, 0, 32'h0,  32'h0,          0, 0, 32'h0,  32'h0, 1, 1, 0, 0, 0, 32'h20, DB,    RD,    32'h0);
    vecs[10] = mk(1, 1, 0, 32'h40, 32'h0,          1, 0, 32'h80, 32'h0, 1, 1, 0, 0, 0, 32'h20, DB,    RD,    32'h0);
    vecs[11] = mk(0, 1, 0, 32'h40, 32'h0,          1, 0, 32'h80, 32'h0, 1, 1, 0, 0, 0, 32'h0,  32'h0, 32'h0, 32'h0);
    vecs[12] = mk(0, 1, 0, 32'h40, 32'h0,          1, 0, 32'h80, 32'h0, 0, 1, 0, 0, 1, 32'h40, 32'h0, 32'h0, 32'h0);
    vecs[13] = mk(0, 1, 0, 32'h40, 32'h0,          1, 0, 32'h80, 32'h0, 0, 1, 0, 0, 1, 32'h40, 32'h0, 32'h0, 32'h0);
    vecs[14] = mk(0, 1, 0, 32'h40, 32'h0,          1, 0, 32'h80, 32'h0, 1, 1, 1, 0, 1, 32'h40, 32'h0, P,     32'h0);
    vecs[15] = mk(0, 0, 0, 32'h0,  32'h0,          1, 0, 32'h80, 32'h0, 1, 1, 0, 0, 0, 32'h40, 32'h0, P,     32'h0);
    vecs[16] = mk(0, 0, 0, 32'h0,  32'h0,          1, 0, 32'h80, 32'h0, 0, 1, 0, 0, 1, 32'h80, 32'h0, P,     32'h0);
    vecs[17] = mk(0, 0, 0, 32'h0,  32'h0,          1, 0, 32'h80, 32'h0, 0, 1, 0, 0, 1, 32'h80, 32'h0, P,     32'h0);
    vecs[18] = mk(0, 0, 0, 32'h0,  32'h0,          1, 0, 32'h80, 32'h0, 1, 1, 0, 1, 1, 32'h80, 32'h0, P,     Q);
    vecs[19] = mk(0, 0, 0, 32'h0,  32'h0,          0, 0, 32'h0,  32'h0, 1, 1, 0, 0, 0, 32'h80, 32'h0, P,     Q);

    repeat (2) @(negedge CLK);
    RST = 1'b0;

    // Vector table: check cycle i outputs, then drive cycle i inputs
    for (int i = 0; i < NV; i++) begin
      @(negedge CLK);
      check_row(i);
      RST = vecs[i].rst;
      drive0(vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].cwd,
             vecs[i].vreq, vecs[i].vwe, vecs[i].vaddr, vecs[i].vwd);
    end
    @(negedge CLK);
    RST = 1'b0;
    drive0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge CLK);

    // Both requesting continuously: alternating grants, fixed period, exclusive strobes
    reset0();
    drive0(1'b1, 1'b1, 32'h300, 32'h0000_C0C0, 1'b1, 1'b0, 32'h400, 32'h0);
    nacks   = 0;
    overlap = 0;
    for (int c = 1; c <= 60 && nacks < 6; c++) begin
      @(negedge CLK);
      if (!bus0.MEM_N_WE && !bus0.MEM_N_OE) overlap++;
      if (bus0.CPU_ACK || bus0.VGA_ACK) begin
        ack_cyc[nacks] = c;
        ack_vga[nacks] = bus0.VGA_ACK;
        nacks++;
      end
    end
    check("rr.ack_count", 32'(nacks), 32'd6);
    check("rr.strobe_overlap", 32'(overlap), 32'd0);
    for (int k = 0; k < nacks; k++) begin
      check_bit($sformatf("rr.grant%0d_is_vga", k), ack_vga[k], (k % 2) == 1);
      check($sformatf("rr.ack%0d_cycle", k), 32'(ack_cyc[k]), 32'(3 + 4 * k));
    end
    check("rr.vga_rdata", bus0.VGA_RDATA, 32'h0400_FBFF);
    check("rr.cpu_rdata_after_writes", bus0.CPU_RDATA, 32'h0);
    drive0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (6) @(negedge CLK);

    // Reset during a VGA read aborts it; next contended grant goes to the CPU
    reset0();
    drive0(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0);   // cycle 0
    @(negedge CLK);                                                  // cycle 1
    check_bit("abort.c1_n_oe", bus0.MEM_N_OE, 1'b0);
    @(negedge CLK);                                                  // cycle 2
    check_bit("abort.c2_n_oe", bus0.MEM_N_OE, 1'b0);
    RST = 1'b1;
    @(negedge CLK);                                                  // cycle 3
    RST = 1'b0;
    check_bit("abort.c3_n_oe", bus0.MEM_N_OE, 1'b1);
    check_bit("abort.c3_n_we", bus0.MEM_N_WE, 1'b1);
    check_bit("abort.c3_vga_ack", bus0.VGA_ACK, 1'b0);
    check_bit("abort.c3_busy", bus0.BUSY, 1'b0);
    drive0(1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0);
    @(negedge CLK);                                                  // cycle 4
    check_bit("abort.c4_vga_ack", bus0.VGA_ACK, 1'b0);
    check("abort.c4_cpu_granted_addr", bus0.MEM_ADDR, 32'h200);
    check("abort.c4_vga_rdata", bus0.VGA_RDATA, 32'h0);
    drive0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge CLK);                                                  // cycle 5
    @(negedge CLK);                                                  // cycle 6
    check_bit("abort.c6_cpu_ack", bus0.CPU_ACK, 1'b1);
    check_bit("abort.c6_vga_ack", bus0.VGA_ACK, 1'b0);
    repeat (3) @(negedge CLK);

    // WAIT_CYCLES=1 instance: single VGA read
    RST1 = 1'b0;
    @(negedge CLK);                                                  // cycle 0
    check_bit("w1.c0_busy", bus1.BUSY, 1'b0);
    bus1.VGA_REQ = 1'b1; bus1.VGA_ADDR = 32'h500;
    @(negedge CLK);                                                  // cycle 1
    check_bit("w1.c1_n_oe", bus1.MEM_N_OE, 1'b0);
    check_bit("w1.c1_busy", bus1.BUSY, 1'b1);
    check_bit("w1.c1_vga_ack", bus1.VGA_ACK, 1'b0);
    @(negedge CLK);                                                  // cycle 2
    check_bit("w1.c2_n_oe", bus1.MEM_N_OE, 1'b1);
    check_bit("w1.c2_vga_ack", bus1.VGA_ACK, 1'b1);
    check_bit("w1.c2_busy", bus1.BUSY, 1'b1);
    check("w1.c2_vga_rdata", bus1.VGA_RDATA, 32'h0500_FAFF);
    bus1.VGA_REQ = 1'b0;
    @(negedge CLK);                                                  // cycle 3
    check_bit("w1.c3_busy", bus1.BUSY, 1'b0);
    check_bit("w1.c3_vga_ack", bus1.VGA_ACK, 1'b0);
    check_bit("w1.c3_cpu_ack", bus1.CPU_ACK, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
